// File: rtl/qe_bus_pkg.sv
// Shared constants for the QL expansion-bus initiator: FSM encoding, card address map, defaults.
package qe_bus_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ADDR  = 3'd1;
  localparam logic [2:0] ST_AS    = 3'd2;
  localparam logic [2:0] ST_DS    = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_LATCH = 3'd5;
  localparam logic [2:0] ST_END   = 3'd6;
  localparam logic [2:0] ST_HOLD  = 3'd7;

  localparam logic [9:0] WIZ_WINDOW    = 10'h320;
  localparam logic [9:0] WIZ_RESET_REG = 10'h324;

  localparam int unsigned QE_TIMEOUT_DEF = 255;

endpackage

// File: rtl/qe_bus_initiator_if.sv
// External 68008-style bus between the initiator (master) and a card responder (slave).
interface qe_bus_initiator_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
);
  logic [ADDR_W-1:0] address;
  logic              asl;
  logic              dsl;
  logic              rdwl;
  logic [DATA_W-1:0] data_out;
  logic              data_oe;
  logic [DATA_W-1:0] data_in;
  logic              dtackl;

  modport master (output address, asl, dsl, rdwl, data_out, data_oe,
                  input  data_in, dtackl);
  modport slave  (input  address, asl, dsl, rdwl, data_out, data_oe,
                  output data_in, dtackl);
endinterface

// File: rtl/qe_sync.sv
// Resettable multi-stage synchroniser for asynchronous bus inputs; resets to all-ones (released bus).
module qe_sync #(
  parameter int unsigned STAGES = 2,
  parameter int unsigned WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] ff [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) ff[i] <= '1;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/qe_bus_initiator.sv
// QL expansion-bus cycle initiator: sequences ASL/DSL/RDWL, waits for DTACKL, reports data or timeout.
// Optional QE_BUS_RETRY_EN: a timed-out cycle is reissued once before done/timeout is reported.
module qe_bus_initiator
  import qe_bus_pkg::*;
#(
  parameter int unsigned ADDR_W         = 10,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned TIMEOUT_CYCLES = QE_TIMEOUT_DEF,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              resetl,
  input  logic              req,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [DATA_W-1:0] rdata,
  qe_bus_initiator_if.master bus
);

  localparam int unsigned CNT_W = 16;

  logic [2:0]        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              flag, flag_d;
  logic              cyc_we, cyc_we_d;
  logic [ADDR_W-1:0] cyc_addr, cyc_addr_d;
  logic [DATA_W-1:0] cyc_wdata, cyc_wdata_d;
  logic              busy_d, done_d, timeout_d;
  logic [DATA_W-1:0] rdata_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              asl_q, asl_d, dsl_q, dsl_d, rdwl_q, rdwl_d, data_oe_q, data_oe_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              dtack_s;
`ifdef QE_BUS_RETRY_EN
  logic              retry, retry_d;
`endif

  qe_sync #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_dtack_sync (
    .clk   (clk),
    .rst_n (resetl),
    .d     (bus.dtackl),
    .q     (dtack_s)
  );

  // Bus pins are decoded from the current state and registered, so they lag the state by one clk.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    flag_d      = flag;
    cyc_we_d    = cyc_we;
    cyc_addr_d  = cyc_addr;
    cyc_wdata_d = cyc_wdata;
    busy_d      = busy;
    done_d      = 1'b0;
    timeout_d   = timeout;
    rdata_d     = rdata;
    address_d   = address_q;
    asl_d       = asl_q;
    dsl_d       = dsl_q;
    rdwl_d      = rdwl_q;
    data_oe_d   = data_oe_q;
    data_out_d  = data_out_q;
`ifdef QE_BUS_RETRY_EN
    retry_d     = retry;
`endif

    if (done) busy_d = 1'b0;

    case (state)
      ST_IDLE: begin
        // A still-asserted DTACKL from the previous cycle must clear before a new cycle starts.
        if (req && !busy && dtack_s) begin
          cyc_we_d    = req_we;
          cyc_addr_d  = req_addr;
          cyc_wdata_d = req_wdata;
          busy_d      = 1'b1;
          state_d     = ST_ADDR;
`ifdef QE_BUS_RETRY_EN
          retry_d     = 1'b0;
`endif
        end
      end
      ST_ADDR: begin
        address_d = cyc_addr;
        rdwl_d    = !cyc_we;
        data_oe_d = cyc_we;
        if (cyc_we) data_out_d = cyc_wdata;
        state_d   = ST_AS;
      end
      ST_AS: begin
        asl_d   = 1'b0;
        state_d = ST_DS;
      end
      ST_DS: begin
        dsl_d   = 1'b0;
        cnt_d   = '0;
        flag_d  = 1'b0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!dtack_s) begin
          state_d = ST_LATCH;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          flag_d  = 1'b1;
          state_d = ST_END;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      ST_LATCH: begin
        if (!cyc_we) rdata_d = bus.data_in;
        state_d = ST_END;
      end
      ST_END: begin
        asl_d   = 1'b1;
        dsl_d   = 1'b1;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        data_oe_d = 1'b0;
        rdwl_d    = 1'b1;
`ifdef QE_BUS_RETRY_EN
        if (flag && !retry) begin
          retry_d = 1'b1;
          state_d = ST_ADDR;
        end else begin
          done_d    = 1'b1;
          timeout_d = flag;
          state_d   = ST_IDLE;
        end
`else
        done_d    = 1'b1;
        timeout_d = flag;
        state_d   = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      flag       <= 1'b0;
      cyc_we     <= 1'b0;
      cyc_addr   <= '0;
      cyc_wdata  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      rdata      <= '0;
      address_q  <= '0;
      asl_q      <= 1'b1;
      dsl_q      <= 1'b1;
      rdwl_q     <= 1'b1;
      data_oe_q  <= 1'b0;
      data_out_q <= '0;
`ifdef QE_BUS_RETRY_EN
      retry      <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      flag       <= flag_d;
      cyc_we     <= cyc_we_d;
      cyc_addr   <= cyc_addr_d;
      cyc_wdata  <= cyc_wdata_d;
      busy       <= busy_d;
      done       <= done_d;
      timeout    <= timeout_d;
      rdata      <= rdata_d;
      address_q  <= address_d;
      asl_q      <= asl_d;
      dsl_q      <= dsl_d;
      rdwl_q     <= rdwl_d;
      data_oe_q  <= data_oe_d;
      data_out_q <= data_out_d;
`ifdef QE_BUS_RETRY_EN
      retry      <= retry_d;
`endif
    end
  end

  assign bus.address  = address_q;
  assign bus.asl      = asl_q;
  assign bus.dsl      = dsl_q;
  assign bus.rdwl     = rdwl_q;
  assign bus.data_oe  = data_oe_q;
  assign bus.data_out = data_out_q;

endmodule
